// File: rtl/ultrasonic_scheduler.sv
// Round-robin M->R->L ultrasonic ranger sequencer: trigger, echo timing, cm conversion.
// Latency: echo edge seen 3 clk after the pin moves; distance registered 1 clk after fall detect.
// No backpressure: results are free-running registers, overwritten on every measurement.
module ultrasonic_scheduler #(
    parameter int TRIG_CYC    = 500,
    parameter int CM_CYC      = 2900,
    parameter int TIMEOUT_CYC = 1500000,
    parameter int GAP_CYC     = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       echo_m,
    input  logic       echo_r,
    input  logic       echo_l,
    output logic       trig_m,
    output logic       trig_r,
    output logic       trig_l,
    output logic [7:0] dist_m,
    output logic [7:0] dist_r,
    output logic [7:0] dist_l,
    output logic [2:0] timeout,
    output logic       frame_done,
    output logic       frame_valid
);

    localparam int CNT_MAX = (TIMEOUT_CYC > GAP_CYC)
                           ? ((TIMEOUT_CYC > TRIG_CYC) ? TIMEOUT_CYC : TRIG_CYC)
                           : ((GAP_CYC > TRIG_CYC) ? GAP_CYC : TRIG_CYC);
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam int SUB_W = $clog2(CM_CYC + 1);

    typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, GAP} state_t;

    state_t             state;
    logic [1:0]         sel;
    logic [2:0]         trig_q;
    logic [CNT_W-1:0]   cnt;
    logic [SUB_W-1:0]   sub_cnt;
    logic [7:0]         cm_cnt;
    logic [2:0]         echo_s1, echo_s2, echo_d;

    logic               e_now, e_prev, rise, fall, to_hit;
    logic [SUB_W-1:0]   sub_base, sub_nx;
    logic [7:0]         cm_base, cm_nx;
    logic               sub_wrap;
    logic               wr_en, wr_to;
    logic [7:0]         wr_val;
    logic [1:0]         sel_nx;

    function automatic logic [2:0] sel_onehot(input logic [1:0] s);
        return 3'b001 << s;
    endfunction

    assign {trig_l, trig_r, trig_m} = trig_q;

    // Only the selected channel's synchronized echo drives the edge detector.
    assign e_now  = echo_s2[sel];
    assign e_prev = echo_d[sel];
    assign rise   = e_now & ~e_prev;
    assign fall   = ~e_now & e_prev;
    assign to_hit = (cnt >= CNT_W'(TIMEOUT_CYC - 1));
    assign sel_nx = (sel == 2'd2) ? 2'd0 : sel + 2'd1;

    // The rise cycle is the first high cycle, so it counts from a zero base.
    assign sub_base = (state == MEASURE) ? sub_cnt : '0;
    assign cm_base  = (state == MEASURE) ? cm_cnt : 8'd0;
    assign sub_wrap = (sub_base == SUB_W'(CM_CYC - 1));
    assign sub_nx   = sub_wrap ? '0 : sub_base + SUB_W'(1);
    assign cm_nx    = (sub_wrap && cm_base != 8'hFF) ? cm_base + 8'd1 : cm_base;

    // A fall on the timeout cycle still reports the measured distance.
    always_comb begin
        wr_en  = 1'b0;
        wr_val = cm_cnt;
        wr_to  = 1'b0;
        if (state == MEASURE && fall) begin
            wr_en = 1'b1;
        end else if ((state == WAIT_RISE || state == MEASURE) && to_hit) begin
            wr_en  = 1'b1;
            wr_val = 8'hFF;
            wr_to  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sel     <= 2'd0;
            trig_q  <= 3'b000;
            cnt     <= '0;
            sub_cnt <= '0;
            cm_cnt  <= 8'd0;
            echo_s1 <= 3'b000;
            echo_s2 <= 3'b000;
            echo_d  <= 3'b000;
        end else begin
            echo_s1 <= {echo_l, echo_r, echo_m};
            echo_s2 <= echo_s1;
            echo_d  <= echo_s2;
            case (state)
                IDLE: begin
                    if (en) begin
                        state  <= TRIG;
                        trig_q <= sel_onehot(sel);
                        cnt    <= '0;
                    end
                end
                TRIG: begin
                    if (cnt == CNT_W'(TRIG_CYC - 1)) begin
                        trig_q <= 3'b000;
                        state  <= WAIT_RISE;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT_RISE, MEASURE: begin
                    if (wr_en) begin
                        state <= GAP;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (state == MEASURE || rise) begin
                            state   <= MEASURE;
                            sub_cnt <= sub_nx;
                            cm_cnt  <= cm_nx;
                        end
                    end
                end
                GAP: begin
                    if (cnt == CNT_W'(GAP_CYC - 1)) begin
                        sel <= sel_nx;
                        cnt <= '0;
                        if (en) begin
                            state  <= TRIG;
                            trig_q <= sel_onehot(sel_nx);
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dist_m      <= 8'd0;
            dist_r      <= 8'd0;
            dist_l      <= 8'd0;
            timeout     <= 3'b000;
            frame_done  <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (wr_en) begin
                case (sel)
                    2'd0: begin
                        dist_m     <= wr_val;
                        timeout[0] <= wr_to;
                    end
                    2'd1: begin
                        dist_r     <= wr_val;
                        timeout[1] <= wr_to;
                    end
                    2'd2: begin
                        dist_l      <= wr_val;
                        timeout[2]  <= wr_to;
                        frame_done  <= 1'b1;
                        frame_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
